// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N FP8 systolic array: skews A/B beats onto the array edges,
// raises the per-PE clear with the first beat's wavefront and flags when c_out is complete.
module systolic_feeder #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [7:0]     k_len,
    output logic           busy,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*8-1:0] in_a,
    input  logic [N*8-1:0] in_b,
    output logic [N*8-1:0] a_edge,
    output logic [N*8-1:0] b_edge,
    output logic [N*N-1:0] clear,
    output logic           done
);

    // DRAIN spans 2N+1 cycles, counted 2N down to 0.
    localparam logic [7:0]  DrainLast = 8'(2 * N);
    localparam int unsigned ClrLen    = 2 * N - 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

    state_e            r_state, w_state_d;
    logic [7:0]        r_k_len, r_beat_cnt, r_drain_cnt;
    logic              w_accept, w_first, w_last, w_feeding;
    logic [N*8-1:0]    w_a_line, w_b_line;
    logic [ClrLen-1:0] r_clr_sr;

    always_comb begin
        in_ready  = (r_state == StLoad) && (r_beat_cnt < r_k_len);
        w_accept  = in_valid && in_ready;
        w_first   = w_accept && (r_beat_cnt == 8'd0);
        w_last    = w_accept && (r_beat_cnt == r_k_len - 8'd1);
        w_feeding = (r_state == StLoad) || (r_state == StDrain);
        busy      = (r_state != StIdle);
        done      = (r_state == StDone);
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (start) w_state_d = (k_len == 8'd0) ? StDone : StLoad;
            StLoad:  if (w_last) w_state_d = StDrain;
            StDrain: if (r_drain_cnt == 8'd0) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_k_len     <= 8'd0;
            r_beat_cnt  <= 8'd0;
            r_drain_cnt <= 8'd0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StIdle && start) begin
                r_k_len    <= k_len;
                r_beat_cnt <= 8'd0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            if (r_state == StLoad && w_last) begin
                r_drain_cnt <= DrainLast;
            end else if (r_state == StDrain && r_drain_cnt != 8'd0) begin
                r_drain_cnt <= r_drain_cnt - 8'd1;
            end
        end
    end

    // Lane g has 1+g stages; unaccepted cycles shift in FP8 zero so accumulators hold.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [7:0] r_a_sr [0:gi];
        logic [7:0] r_b_sr [0:gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= gi; k++) begin
                    r_a_sr[k] <= 8'h00;
                    r_b_sr[k] <= 8'h00;
                end
            end else begin
                r_a_sr[0] <= w_accept ? in_a[gi*8 +: 8] : 8'h00;
                r_b_sr[0] <= w_accept ? in_b[gi*8 +: 8] : 8'h00;
                for (int k = 1; k <= gi; k++) begin
                    r_a_sr[k] <= r_a_sr[k-1];
                    r_b_sr[k] <= r_b_sr[k-1];
                end
            end
        end

        assign w_a_line[gi*8 +: 8] = r_a_sr[gi];
        assign w_b_line[gi*8 +: 8] = r_b_sr[gi];
    end

    assign a_edge = w_feeding ? w_a_line : '0;
    assign b_edge = w_feeding ? w_b_line : '0;

    // Stage k is high in cycle t0+1+k; PE(i,j) taps stage i+j of the first-beat wavefront.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_sr <= '0;
        end else begin
            r_clr_sr[0] <= w_first;
            for (int k = 1; k < ClrLen; k++) begin
                r_clr_sr[k] <= r_clr_sr[k-1];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_clr_row
        for (genvar gj = 0; gj < N; gj++) begin : g_clr_col
            assign clear[gi*N+gj] = r_clr_sr[gi+gj];
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomised bench for systolic_feeder against a timeline model of tiles, beats and resets.
module tb_systolic_feeder;

    localparam int N = 4;
    localparam int W = N * 8;

    logic           clk = 1'b0;
    logic           rst, start, in_valid;
    logic [7:0]     k_len;
    logic [W-1:0]   in_a, in_b, a_edge, b_edge;
    logic [N*N-1:0] clear;
    logic           busy, in_ready, done;

    int errors = 0;
    int checks = 0;
    int n_pos  = 0;

    // Model: cycle c is the period ending at edge c.
    bit           tile_active = 1'b0;
    int           tile_k      = 0;
    int           beats       = 0;
    int           t_first     = -1;
    int           done_cyc    = -1;
    int           last_rst    = -1000;
    logic [W-1:0] hist_a [int];
    logic [W-1:0] hist_b [int];

    logic [W-1:0]   exp_a, exp_b;
    logic [N*N-1:0] exp_clear;
    logic           exp_done, exp_busy, exp_ready;

    systolic_feeder #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .k_len    (k_len),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .a_edge   (a_edge),
        .b_edge   (b_edge),
        .clear    (clear),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [W-1:0] rnd_word();
        rnd_word = $urandom;
    endfunction

    task automatic model_edge();
        int e;
        n_pos++;
        e = n_pos;
        if (rst) begin
            tile_active = 1'b0;
            last_rst    = e;
        end else if (tile_active && e == done_cyc) begin
            tile_active = 1'b0;
        end else if (!tile_active) begin
            if (start) begin
                tile_active = 1'b1;
                tile_k      = int'(k_len);
                beats       = 0;
                t_first     = -1;
                done_cyc    = (k_len == 8'd0) ? e + 1 : -1;
            end
        end else if (beats < tile_k && in_valid) begin
            hist_a[e] = in_a;
            hist_b[e] = in_b;
            if (beats == 0) t_first = e;
            beats++;
            if (beats == tile_k) done_cyc = e + 2 * N + 2;
        end
    endtask

    task automatic compute_exp();
        int cur, t;
        logic [W-1:0] wa, wb;
        cur       = n_pos + 1;
        exp_busy  = tile_active;
        exp_ready = tile_active && (beats < tile_k);
        exp_done  = tile_active && (cur == done_cyc);
        exp_a     = '0;
        exp_b     = '0;
        exp_clear = '0;
        for (int i = 0; i < N; i++) begin
            t = cur - 1 - i;
            if (tile_active && cur != done_cyc && t > last_rst && hist_a.exists(t)) begin
                wa = hist_a[t];
                wb = hist_b[t];
                exp_a[i*8 +: 8] = wa[i*8 +: 8];
                exp_b[i*8 +: 8] = wb[i*8 +: 8];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (t_first >= 0 && t_first > last_rst && cur == t_first + 1 + i + j)
                    exp_clear[i*N+j] = 1'b1;
            end
        end
    endtask

    task automatic step(input logic s, input logic [7:0] kl, input logic v,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
        start    = s;
        k_len    = kl;
        in_valid = v;
        in_a     = a;
        in_b     = b;
        rst      = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compute_exp();
    endtask

    task automatic idle();
        step(1'b0, 8'd0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 8'd3, 1'b1, '1, '1, 1'b1);
        step(1'b0, 8'd0, 1'b0, '0, '0, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (a_edge !== '0) begin errors++; $display("FAIL reset_a_edge: got %h want 0", a_edge); end
        checks++; if (b_edge !== '0) begin errors++; $display("FAIL reset_b_edge: got %h want 0", b_edge); end
        checks++; if (clear !== '0) begin errors++; $display("FAIL reset_clear: got %h want 0", clear); end
    endtask

    task automatic test_single_beat();
        int ts, done_at, clr_sum;
        done_at = -1;
        clr_sum = 0;
        step(1'b1, 8'd1, 1'b0, '0, '0, 1'b0);
        ts = n_pos;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        step(1'b0, 8'd0, 1'b1, 32'h38383838, 32'h38383838, 1'b0);
        for (int c = 0; c < 13; c++) begin
            checks++;
            if ({a_edge, b_edge} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL single_skew cyc=%0d: got a=%h b=%h want a=%h b=%h",
                         n_pos + 1 - ts, a_edge, b_edge, exp_a, exp_b);
            end
            checks++;
            if (clear !== exp_clear) begin
                errors++;
                $display("FAIL single_clear cyc=%0d: got %h want %h", n_pos + 1 - ts, clear, exp_clear);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL single_done cyc=%0d: got %b want %b", n_pos + 1 - ts, done, exp_done);
            end
            clr_sum += $countones(clear);
            if (done === 1'b1) done_at = n_pos + 1;
            idle();
        end
        checks++; if (done_at != ts + 11) begin errors++; $display("FAIL single_done_cycle: got %0d want %0d", done_at - ts, 11); end
        checks++; if (clr_sum != N * N) begin errors++; $display("FAIL single_clear_count: got %0d want %0d", clr_sum, N * N); end
    endtask

    task automatic test_back_to_back();
        int ts, n_acc, n_done, done_at;
        n_acc = 0; n_done = 0; done_at = -1;
        step(1'b1, 8'd3, 1'b0, '0, '0, 1'b0);
        ts = n_pos;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (in_ready !== exp_ready) begin
                errors++; $display("FAIL b2b_ready cyc=%0d: got %b want %b", c, in_ready, exp_ready);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++; $display("FAIL b2b_busy cyc=%0d: got %b want %b", c, busy, exp_busy);
            end
            checks++;
            if ({a_edge, b_edge} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL b2b_skew cyc=%0d: got a=%h b=%h want a=%h b=%h", c, a_edge, b_edge, exp_a, exp_b);
            end
            if (in_ready === 1'b1) n_acc++;
            if (done === 1'b1) begin n_done++; done_at = n_pos + 1; end
            step(1'b0, 8'd0, 1'b1, rnd_word(), rnd_word(), 1'b0);
        end
        checks++; if (n_acc != 3) begin errors++; $display("FAIL b2b_beats: got %0d want 3", n_acc); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d want 1", n_done); end
        checks++; if (done_at != ts + 13) begin errors++; $display("FAIL b2b_done_cycle: got %0d want %0d", done_at - ts, 13); end
    endtask

    task automatic test_bubbles();
        int ts, done_at, clr_sum;
        logic [17:0] pat;
        pat = 18'h00009;
        done_at = -1; clr_sum = 0;
        step(1'b1, 8'd2, 1'b0, '0, '0, 1'b0);
        ts = n_pos;
        for (int c = 0; c < 18; c++) begin
            checks++;
            if ({a_edge, b_edge} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL bubble_skew cyc=%0d: got a=%h b=%h want a=%h b=%h", c, a_edge, b_edge, exp_a, exp_b);
            end
            checks++;
            if (clear !== exp_clear) begin
                errors++; $display("FAIL bubble_clear cyc=%0d: got %h want %h", c, clear, exp_clear);
            end
            checks++;
            if (done !== exp_done) begin
                errors++; $display("FAIL bubble_done cyc=%0d: got %b want %b", c, done, exp_done);
            end
            clr_sum += $countones(clear);
            if (done === 1'b1) done_at = n_pos + 1;
            step(1'b0, 8'd0, pat[c], rnd_word(), rnd_word(), 1'b0);
        end
        checks++; if (done_at != ts + 14) begin errors++; $display("FAIL bubble_done_cycle: got %0d want %0d", done_at - ts, 14); end
        checks++; if (clr_sum != N * N) begin errors++; $display("FAIL bubble_clear_count: got %0d want %0d", clr_sum, N * N); end
    endtask

    task automatic test_reset_drain();
        int ts, done_at, n_done;
        done_at = -1; n_done = 0;
        step(1'b1, 8'd2, 1'b0, '0, '0, 1'b0);
        step(1'b0, 8'd0, 1'b1, rnd_word(), rnd_word(), 1'b0);
        step(1'b0, 8'd0, 1'b1, rnd_word(), rnd_word(), 1'b0);
        repeat (3) idle();
        step(1'b1, 8'd5, 1'b1, rnd_word(), rnd_word(), 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstdrain_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstdrain_ready: got %b want 0", in_ready); end
        checks++; if ({a_edge, b_edge} !== '0) begin errors++; $display("FAIL rstdrain_edges: got %h want 0", {a_edge, b_edge}); end
        checks++; if (clear !== '0) begin errors++; $display("FAIL rstdrain_clear: got %h want 0", clear); end
        for (int c = 0; c < 12; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) n_done++;
            idle();
        end
        checks++; if (n_done != 0) begin errors++; $display("FAIL rstdrain_quiet: got %0d active cycles want 0", n_done); end
        step(1'b1, 8'd1, 1'b0, '0, '0, 1'b0);
        ts = n_pos;
        step(1'b0, 8'd0, 1'b1, rnd_word(), rnd_word(), 1'b0);
        for (int c = 0; c < 13; c++) begin
            checks++;
            if ({a_edge, b_edge, clear, done} !== {exp_a, exp_b, exp_clear, exp_done}) begin
                errors++;
                $display("FAIL rstdrain_retile cyc=%0d: got %h want %h", c,
                         {a_edge, b_edge, clear, done}, {exp_a, exp_b, exp_clear, exp_done});
            end
            if (done === 1'b1) done_at = n_pos + 1;
            idle();
        end
        checks++; if (done_at != ts + 11) begin errors++; $display("FAIL rstdrain_done_cycle: got %0d want %0d", done_at - ts, 11); end
    endtask

    task automatic test_zero_len();
        step(1'b1, 8'd0, 1'b1, rnd_word(), rnd_word(), 1'b0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b want 1", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_ready: got %b want 0", in_ready); end
        checks++; if (clear !== '0) begin errors++; $display("FAIL zero_clear: got %h want 0", clear); end
        step(1'b0, 8'd0, 1'b1, rnd_word(), rnd_word(), 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_after: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after: got %b want 0", busy); end
        checks++; if ({in_ready, clear} !== '0) begin errors++; $display("FAIL zero_quiet_after: got %h want 0", {in_ready, clear}); end
    endtask

    task automatic test_start_while_busy();
        int ts, n_acc, done_at;
        n_acc = 0; done_at = -1;
        step(1'b1, 8'd2, 1'b0, '0, '0, 1'b0);
        ts = n_pos;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (in_ready !== exp_ready) begin
                errors++; $display("FAIL busy_start_ready cyc=%0d: got %b want %b", c, in_ready, exp_ready);
            end
            checks++;
            if (done !== exp_done) begin
                errors++; $display("FAIL busy_start_done cyc=%0d: got %b want %b", c, done, exp_done);
            end
            if (in_ready === 1'b1) n_acc++;
            if (done === 1'b1) done_at = n_pos + 1;
            step(c < 6, 8'd9, 1'b1, rnd_word(), rnd_word(), 1'b0);
        end
        checks++; if (n_acc != 2) begin errors++; $display("FAIL busy_start_beats: got %0d want 2", n_acc); end
        checks++; if (done_at != ts + 12) begin errors++; $display("FAIL busy_start_done_cycle: got %0d want %0d", done_at - ts, 12); end
    endtask

    task automatic test_random();
        int n_done, budget;
        n_done = 0;
        for (int tile = 0; tile < 6; tile++) begin
            step(1'b1, 8'($urandom_range(1, 6)), 1'b0, '0, '0, 1'b0);
            budget = 80;
            while (exp_busy && budget > 0) begin
                checks++;
                if ({busy, in_ready, done} !== {exp_busy, exp_ready, exp_done}) begin
                    errors++;
                    $display("FAIL rand_ctrl tile=%0d: got busy/ready/done=%b want %b", tile,
                             {busy, in_ready, done}, {exp_busy, exp_ready, exp_done});
                end
                checks++;
                if ({a_edge, b_edge, clear} !== {exp_a, exp_b, exp_clear}) begin
                    errors++;
                    $display("FAIL rand_data tile=%0d: got %h want %h", tile,
                             {a_edge, b_edge, clear}, {exp_a, exp_b, exp_clear});
                end
                if (done === 1'b1) n_done++;
                step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 2) != 0,
                     rnd_word(), rnd_word(), 1'b0);
                budget--;
            end
            if (budget == 0) begin
                errors++;
                $display("FAIL rand_timeout tile=%0d: still busy after 80 cycles", tile);
                step(1'b0, 8'd0, 1'b0, '0, '0, 1'b1);
            end
            checks++;
            if ({busy, a_edge, b_edge, clear} !== '0) begin
                errors++; $display("FAIL rand_idle tile=%0d: got %h want 0", tile, {busy, a_edge, b_edge, clear});
            end
        end
        checks++; if (n_done != 6) begin errors++; $display("FAIL rand_done_pulses: got %0d want 6", n_done); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_len = 8'd0; in_valid = 1'b0; in_a = '0; in_b = '0;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_bubbles();
        test_reset_drain();
        test_zero_len();
        test_start_while_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
